// File: rtl/seg7_scan_ctrl_if.sv
// Host-side load/enable signals and scanned display outputs of the 7-segment controller.
interface seg7_scan_ctrl_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic                      enable;
  logic                      load_valid;
  logic [4*NUM_DIGITS-1:0]   load_data;
  logic [NUM_DIGITS-1:0]     load_dp;
  logic [NUM_DIGITS-1:0]     digit_en;
  logic [6:0]                segments;
  logic                      dp;
  logic                      frame_done;

  modport master (
    output enable, load_valid, load_data, load_dp,
    input  digit_en, segments, dp, frame_done
  );

  modport slave (
    input  enable, load_valid, load_data, load_dp,
    output digit_en, segments, dp, frame_done
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scanner: per-digit blank/show slots, double-buffered
// digit data that only switches over at frame boundaries.
module seg7_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned SLOT_CYCLES  = 50000,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic             clk,
  input  logic             rst,
  seg7_scan_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [4*NUM_DIGITS-1:0] active_q, active_d;
  logic [NUM_DIGITS-1:0]   active_dp_q, active_dp_d;
  logic                    pending_q, pending_d;
  logic [NUM_DIGITS-1:0]   digit_en_q, digit_en_d;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic                    frame_done_q, frame_done_d;
  logic                    boundary;
  logic [3:0]              nib;
  logic                    dp_sel;
  logic [NUM_DIGITS-1:0]   onehot;

  function automatic logic [6:0] decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = '0;
    endcase
    return s;
  endfunction

  // The slot counter runs across the whole slot; BLANK covers the first
  // BLANK_CYCLES counts and SHOW the remainder.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    frame_done_d = 1'b0;
    boundary     = 1'b0;

    if (!bus.enable) begin
      state_d = ST_OFF;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d  = ST_BLANK;
          idx_d    = '0;
          cnt_d    = '0;
          boundary = 1'b1;
        end
        ST_BLANK: begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) state_d = ST_SHOW;
        end
        ST_SHOW: begin
          if (cnt_q == CNT_W'(SLOT_CYCLES - 1)) begin
            cnt_d   = '0;
            state_d = ST_BLANK;
            if (idx_q == IDX_W'(NUM_DIGITS - 1)) begin
              idx_d        = '0;
              boundary     = 1'b1;
              frame_done_d = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = ST_OFF;
      endcase
    end
  end

  // A strobe landing on a frame boundary goes straight to the active buffer.
  always_comb begin
    shadow_d    = shadow_q;
    shadow_dp_d = shadow_dp_q;
    active_d    = active_q;
    active_dp_d = active_dp_q;
    pending_d   = pending_q;

    if (bus.load_valid) begin
      shadow_d    = bus.load_data;
      shadow_dp_d = bus.load_dp;
      pending_d   = 1'b1;
    end
    if (boundary) begin
      pending_d = 1'b0;
      if (bus.load_valid) begin
        active_d    = bus.load_data;
        active_dp_d = bus.load_dp;
      end else if (pending_q) begin
        active_d    = shadow_q;
        active_dp_d = shadow_dp_q;
      end
    end
  end

  always_comb begin
    nib    = '0;
    dp_sel = 1'b0;
    onehot = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        nib       = active_d[4*i +: 4];
        dp_sel    = active_dp_d[i];
        onehot[i] = 1'b1;
      end
    end
    digit_en_d = '0;
    seg_d      = '0;
    dp_d       = 1'b0;
    if (state_d == ST_SHOW) begin
      digit_en_d = onehot;
      seg_d      = decode(nib);
      dp_d       = dp_sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_OFF;
      idx_q        <= '0;
      cnt_q        <= '0;
      shadow_q     <= '0;
      shadow_dp_q  <= '0;
      active_q     <= '0;
      active_dp_q  <= '0;
      pending_q    <= 1'b0;
      digit_en_q   <= '0;
      seg_q        <= '0;
      dp_q         <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      shadow_q     <= shadow_d;
      shadow_dp_q  <= shadow_dp_d;
      active_q     <= active_d;
      active_dp_q  <= active_dp_d;
      pending_q    <= pending_d;
      digit_en_q   <= digit_en_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.digit_en   = digit_en_q;
  assign bus.segments   = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: a frame-time reference model queues the
// expected outputs each clock; a monitor compares them on the falling edge.
module tb_seg7_scan_ctrl;

  localparam int unsigned ND    = 4;
  localparam int unsigned SC    = 8;
  localparam int unsigned BC    = 2;
  localparam int unsigned FRAME = ND * SC;

  localparam logic [6:0] SEG_LUT [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b0000000, 7'b0000000,
    7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000
  };

  typedef struct packed {
    logic [ND-1:0] en;
    logic [6:0]    seg;
    logic          dp;
    logic          fd;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg7_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

  seg7_scan_ctrl #(
    .NUM_DIGITS  (ND),
    .SLOT_CYCLES (SC),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model: position within the frame is a plain cycle count since
  // the scan started; digit and blank/show follow by division.
  bit             running;
  int unsigned    t;
  logic [4*ND-1:0] act, shd;
  logic [ND-1:0]  act_dp, shd_dp;
  bit             pend;

  initial begin
    obs_t        e;
    bit          bnd, fd;
    int unsigned d;
    logic [3:0]  n;
    logic [ND-1:0] one;
    one = 1;
    forever begin
      @(posedge clk or posedge rst);
      e = '0;
      if (rst) begin
        running = 0; t = 0; pend = 0;
        act = '0; shd = '0; act_dp = '0; shd_dp = '0;
        exp_q.delete();
      end else begin
        bnd = 0; fd = 0;
        if (!bus.enable) begin
          running = 0; t = 0;
        end else if (!running) begin
          running = 1; t = 0; bnd = 1;
        end else begin
          t++;
          if (t == FRAME) begin
            t = 0; bnd = 1; fd = 1;
          end
        end
        if (bnd && bus.load_valid) begin
          act = bus.load_data; act_dp = bus.load_dp;
          shd = bus.load_data; shd_dp = bus.load_dp;
          pend = 0;
        end else if (bnd && pend) begin
          act = shd; act_dp = shd_dp; pend = 0;
        end else if (bus.load_valid) begin
          shd = bus.load_data; shd_dp = bus.load_dp; pend = 1;
        end
        if (running && (t % SC) >= BC) begin
          d     = t / SC;
          n     = act[4*d +: 4];
          e.en  = one << d;
          e.seg = SEG_LUT[n];
          e.dp  = act_dp[d];
        end
        e.fd = fd;
      end
      exp_q.push_back(e);
    end
  end

  initial begin
    obs_t o, e;
    forever begin
      @(negedge clk);
      o.en  = bus.digit_en;
      o.seg = bus.segments;
      o.dp  = bus.dp;
      o.fd  = bus.frame_done;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_underflow @%0t: no expected entry for en=%b seg=%b", $time, o.en, o.seg);
      end else begin
        e = exp_q.pop_front();
        if (o !== e) begin
          n_bad++;
          $display("FAIL outputs @%0t: got en=%b seg=%b dp=%b fd=%b, expected en=%b seg=%b dp=%b fd=%b",
                   $time, o.en, o.seg, o.dp, o.fd, e.en, e.seg, e.dp, e.fd);
        end
      end
    end
  end

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic load(input logic [4*ND-1:0] d, input logic [ND-1:0] m);
    bus.load_valid = 1'b1;
    bus.load_data  = d;
    bus.load_dp    = m;
    step(1);
    bus.load_valid = 1'b0;
  endtask

  initial begin
    int unsigned w;
    bus.enable     = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.load_dp    = '0;
    step(3);
    rst = 1'b0;
    step(1);

    load(16'h4321, 4'b0000);
    bus.enable = 1'b1;
    step(1);                      // frame start edge E0
    step(10);                     // t=10: digit 1 showing
    load(16'h8888, 4'b0000);      // captured at E11, held until E32
    step(52);                     // now just after E63
    load(16'h0005, 4'b0000);      // coincides with the wrap at E64
    load(16'h0A00, 4'b0100);      // blank nibble with dp on digit 2
    step(70);                     // just after E135 (t=7 of the frame at E128)
    step(12);                     // t=19: digit 2 showing
    bus.enable = 1'b0;
    step(5);
    bus.enable = 1'b1;
    step(40);

    // asynchronous reset in the middle of a show slot
    w = 0;
    while (bus.digit_en == '0 && w < 64) begin
      @(posedge clk);
      w++;
    end
    n_cmp++;
    if (w >= 64) begin
      n_bad++;
      $display("FAIL show_timeout: digit_en stayed %b for %0d cycles, required nonzero", bus.digit_en, w);
    end
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_cmp++;
    if ({bus.digit_en, bus.segments, bus.dp, bus.frame_done} !== '0) begin
      n_bad++;
      $display("FAIL async_rst: got en=%b seg=%b dp=%b fd=%b, required all 0",
               bus.digit_en, bus.segments, bus.dp, bus.frame_done);
    end
    @(posedge clk);
    #2 rst = 1'b0;
    step(40);

    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(11) == 0) begin
        bus.load_valid = 1'b1;
        bus.load_data  = 16'($urandom);
        bus.load_dp    = 4'($urandom);
      end else begin
        bus.load_valid = 1'b0;
      end
      if ($urandom_range(149) == 0) bus.enable = ~bus.enable;
      step(1);
    end
    bus.load_valid = 1'b0;
    bus.enable     = 1'b0;
    step(3);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
